// File: rtl/uart_rgb_pwm.sv
// rtl/uart_rgb_pwm.sv - UART-driven RGB PWM: frames A5 r g b set the duties, each frame is acked with 'K'
module uart_rgb_pwm #(
  parameter int CLK_HZ = 48000000,
  parameter int BAUD   = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx,
  output logic led_r,
  output logic led_g,
  output logic led_b
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h4B;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {SYNC, GET_R, GET_G, GET_B} ps_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  logic rst_meta, rst_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  // rx_d is the previous synchronized sample, used for falling-edge detection
  logic rx_meta, rx_s, rx_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  rx_state_t rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_tick, byte_valid, frame_err;

  always_comb begin
    rx_state_n = rx_state;
    rx_tick    = 1'b0;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_d && !rx_s) rx_state_n = RX_START;
      RX_START: if (rx_cnt == CW'(HALF - 1)) begin
        rx_tick    = 1'b1;
        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA:  if (rx_cnt == CW'(DIV - 1)) begin
        rx_tick = 1'b1;
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
      end
      RX_STOP:  if (rx_cnt == CW'(DIV - 1)) begin
        rx_tick = 1'b1;
        if (rx_s) begin
          byte_valid = 1'b1;
          rx_state_n = RX_IDLE;
        end else begin
          frame_err  = 1'b1;
          rx_state_n = RX_WAIT;
        end
      end
      RX_WAIT:  if (rx_s) rx_state_n = RX_IDLE;
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + CW'(1);
      if (rx_tick && rx_state == RX_DATA) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  ps_t  ps, ps_n;
  logic frame_done;

  always_comb begin
    ps_n       = ps;
    frame_done = 1'b0;
    if (frame_err) begin
      ps_n = SYNC;
    end else if (byte_valid) begin
      case (ps)
        SYNC:    if (rx_shift == SYNC_BYTE) ps_n = GET_R;
        GET_R:   ps_n = GET_G;
        GET_G:   ps_n = GET_B;
        GET_B: begin
          ps_n       = SYNC;
          frame_done = 1'b1;
        end
        default: ps_n = SYNC;
      endcase
    end
  end

  logic [7:0] shadow_r, shadow_g, shadow_b, duty_r, duty_g, duty_b, cnt;
  logic       update_pending;

  // Duties only change at the wrap so every PWM period is whole
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps             <= SYNC;
      shadow_r       <= '0;
      shadow_g       <= '0;
      shadow_b       <= '0;
      duty_r         <= '0;
      duty_g         <= '0;
      duty_b         <= '0;
      cnt            <= '0;
      update_pending <= 1'b0;
      led_r          <= 1'b0;
      led_g          <= 1'b0;
      led_b          <= 1'b0;
    end else begin
      ps  <= ps_n;
      cnt <= cnt + 8'd1;
      if (frame_err) begin
        shadow_r <= '0;
        shadow_g <= '0;
        shadow_b <= '0;
      end else if (byte_valid) begin
        if (ps == GET_R) shadow_r <= rx_shift;
        if (ps == GET_G) shadow_g <= rx_shift;
        if (ps == GET_B) shadow_b <= rx_shift;
      end
      if (cnt == 8'hFF && update_pending) begin
        duty_r <= shadow_r;
        duty_g <= shadow_g;
        duty_b <= shadow_b;
      end
      if (frame_done) update_pending <= 1'b1;
      else if (cnt == 8'hFF) update_pending <= 1'b0;
      led_r <= cnt < duty_r;
      led_g <= cnt < duty_g;
      led_b <= cnt < duty_b;
    end
  end

  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;
  logic          tx_tick;

  always_comb begin
    tx_state_n = tx_state;
    tx_tick    = (tx_cnt == CW'(DIV - 1));
    case (tx_state)
      TX_IDLE: if (frame_done) tx_state_n = TX_BUSY;
      TX_BUSY: if (tx_tick && tx_bit == 4'd9) tx_state_n = TX_IDLE;
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Ack requests arriving while busy are ignored; the shift register back-fills with stop level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      if (tx_state == TX_IDLE) begin
        tx_cnt <= '0;
        tx_bit <= '0;
        if (frame_done) begin
          tx       <= 1'b0;
          tx_shift <= {1'b1, ACK_BYTE};
        end
      end else if (tx_tick) begin
        tx_cnt   <= '0;
        tx_bit   <= tx_bit + 4'd1;
        tx       <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end
endmodule
